// File: rtl/cascade_pi_pwm.sv
// cascade_pi_pwm: outer and inner PI loops evaluated in sequence on one shared
// multiplier, with conditional-integration anti-windup, feeding a PWM
// generator whose duty and period reload only at the period boundary.
module cascade_pi_pwm #(
  parameter int unsigned ADC_W  = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned PWM_W  = 10,
  parameter int unsigned CENTER = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] setpoint,
  input  logic [ADC_W-1:0] outer_meas,
  input  logic [ADC_W-1:0] inner_meas,
  input  logic [15:0]      kp_outer,
  input  logic [15:0]      ki_outer,
  input  logic [15:0]      kp_inner,
  input  logic [15:0]      ki_inner,
  input  logic [ADC_W-1:0] outer_max,
  input  logic [PWM_W-1:0] pwm_period,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [PWM_W-1:0] duty_cmd,
  output logic             pwm_out
);

  localparam int unsigned ProdW = DATA_W + 16;

  localparam logic signed [DATA_W-1:0] SMax = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMin = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [3:0] StIdle = 4'd0;
  localparam logic [3:0] StErr1 = 4'd1;
  localparam logic [3:0] StP1   = 4'd2;
  localparam logic [3:0] StI1   = 4'd3;
  localparam logic [3:0] StSum1 = 4'd4;
  localparam logic [3:0] StErr2 = 4'd5;
  localparam logic [3:0] StP2   = 4'd6;
  localparam logic [3:0] StI2   = 4'd7;
  localparam logic [3:0] StSum2 = 4'd8;
  localparam logic [3:0] StDone = 4'd9;

  function automatic logic signed [DATA_W-1:0] zext_adc(input logic [ADC_W-1:0] x);
    zext_adc = {{(DATA_W-ADC_W){1'b0}}, x};
  endfunction

  function automatic logic signed [DATA_W-1:0] zext_pwm(input logic [PWM_W-1:0] x);
    zext_pwm = {{(DATA_W-PWM_W){1'b0}}, x};
  endfunction

  // Saturate a full-width product to DATA_W: fits only if the top bits are all sign copies.
  function automatic logic signed [DATA_W-1:0] sat_prod(input logic signed [ProdW-1:0] x);
    logic [ProdW-DATA_W:0] top;
    top = x[ProdW-1:DATA_W-1];
    if (top == {(ProdW-DATA_W+1){x[ProdW-1]}}) begin
      sat_prod = x[DATA_W-1:0];
    end else if (x[ProdW-1]) begin
      sat_prod = SMin;
    end else begin
      sat_prod = SMax;
    end
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      sat_add = sum[DATA_W] ? SMin : SMax;
    end else begin
      sat_add = sum[DATA_W-1:0];
    end
  endfunction

  logic [3:0]               state_q, state_d;
  logic [ADC_W-1:0]         sp_q, sp_d, om_q, om_d, im_q, im_d;
  logic signed [DATA_W-1:0] e_q, e_d, p_q, p_d, c_q, c_d, inc_q, inc_d;
  logic signed [DATA_W-1:0] integ1_q, integ1_d, integ2_q, integ2_d, u1_q, u1_d;
  logic [PWM_W-1:0]         duty_cmd_q, duty_cmd_d;
  logic                     overrun_q, overrun_d;

  logic [15:0]              gain;
  logic signed [ProdW-1:0]  prod;
  logic signed [DATA_W-1:0] mul_sat;
  logic signed [DATA_W-1:0] sum_s, sum_hi, sum_clamped;
  logic                     windup_ok;

  // Shared multiplier: gain picked by the current P/I step.
  always_comb begin
    gain = '0;
    case (state_q)
      StP1:    gain = kp_outer;
      StI1:    gain = ki_outer;
      StP2:    gain = kp_inner;
      StI2:    gain = ki_inner;
      default: gain = '0;
    endcase
  end

  assign prod    = $signed({{DATA_W{gain[15]}}, gain}) * $signed({{16{e_q[DATA_W-1]}}, e_q});
  assign mul_sat = sat_prod(prod >>> FRAC);

  // Loop output clamp and anti-windup decision for whichever SUM step is active.
  always_comb begin
    sum_s       = sat_add(p_q, c_q);
    sum_hi      = (state_q == StSum1) ? zext_adc(outer_max) : zext_pwm(pwm_period);
    sum_clamped = sum_s;
    if (sum_s < 0) begin
      sum_clamped = '0;
    end else if (sum_s > sum_hi) begin
      sum_clamped = sum_hi;
    end
    // Integrate only when it cannot push the output further into the clamp.
    windup_ok = ((sum_s >= 0) && (sum_s <= sum_hi)) ||
                ((sum_s > sum_hi) && (inc_q < 0)) ||
                ((sum_s < 0) && (inc_q > 0));
  end

  // Sequencer and datapath next state.
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    om_d       = om_q;
    im_d       = im_q;
    e_d        = e_q;
    p_d        = p_q;
    c_d        = c_q;
    inc_d      = inc_q;
    integ1_d   = integ1_q;
    integ2_d   = integ2_q;
    u1_d       = u1_q;
    duty_cmd_d = duty_cmd_q;
    case (state_q)
      StIdle: begin
        if (sample_valid) begin
          sp_d    = setpoint;
          om_d    = outer_meas;
          im_d    = inner_meas;
          state_d = StErr1;
        end
      end
      StErr1: begin
        e_d     = zext_adc(sp_q) - zext_adc(om_q);
        state_d = StP1;
      end
      StP1: begin
        p_d     = mul_sat;
        state_d = StI1;
      end
      StI1: begin
        inc_d   = mul_sat;
        c_d     = sat_add(integ1_q, mul_sat);
        state_d = StSum1;
      end
      StSum1: begin
        u1_d = sum_clamped;
        if (windup_ok) integ1_d = c_q;
        state_d = StErr2;
      end
      StErr2: begin
        e_d     = u1_q - zext_adc(im_q);
        state_d = StP2;
      end
      StP2: begin
        p_d     = mul_sat;
        state_d = StI2;
      end
      StI2: begin
        inc_d   = mul_sat;
        c_d     = sat_add(integ2_q, mul_sat);
        state_d = StSum2;
      end
      StSum2: begin
        duty_cmd_d = sum_clamped[PWM_W-1:0];
        if (windup_ok) integ2_d = c_q;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Disable aborts any computation and discards loop history.
    if (!enable) begin
      state_d    = StIdle;
      integ1_d   = '0;
      integ2_d   = '0;
      duty_cmd_d = '0;
    end
  end

  assign overrun_d = sample_valid && (state_q != StIdle);

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sp_q       <= '0;
      om_q       <= '0;
      im_q       <= '0;
      e_q        <= '0;
      p_q        <= '0;
      c_q        <= '0;
      inc_q      <= '0;
      integ1_q   <= '0;
      integ2_q   <= '0;
      u1_q       <= '0;
      duty_cmd_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      om_q       <= om_d;
      im_q       <= im_d;
      e_q        <= e_d;
      p_q        <= p_d;
      c_q        <= c_d;
      inc_q      <= inc_d;
      integ1_q   <= integ1_d;
      integ2_q   <= integ2_d;
      u1_q       <= u1_d;
      duty_cmd_q <= duty_cmd_d;
      overrun_q  <= overrun_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign overrun  = overrun_q;
  assign duty_cmd = duty_cmd_q;

  // ---------------------------------------------------------------------------------------------
  // PWM generator
  // ---------------------------------------------------------------------------------------------
  logic [PWM_W-1:0] cnt_q, cnt_d, duty_act_q, duty_act_d, p_act_q, p_act_d;
  logic             dir_q, dir_d, pwm_q, pwm_d;
  logic             peak, falling;

  // Counter, boundary reload and compare; duty/period latch as the count returns to 0,
  // so every period runs entirely on one duty value.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (p_act_q == '0) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (CENTER == 0) begin
      cnt_d = (cnt_q >= p_act_q - PWM_W'(1)) ? '0 : cnt_q + PWM_W'(1);
    end else if (!dir_q) begin
      if (cnt_q >= p_act_q) begin
        cnt_d = cnt_q - PWM_W'(1);
        dir_d = (cnt_q != PWM_W'(1));
      end else begin
        cnt_d = cnt_q + PWM_W'(1);
      end
    end else begin
      cnt_d = cnt_q - PWM_W'(1);
      if (cnt_q == PWM_W'(1)) dir_d = 1'b0;
    end

    duty_act_d = duty_act_q;
    p_act_d    = p_act_q;
    if (cnt_d == '0) begin
      duty_act_d = duty_cmd_q;
      p_act_d    = pwm_period;
    end

    // Triangle: the falling half (peak included) uses <= so the pulse is 2*duty wide,
    // symmetric about cnt = 0, and duty >= P yields a solid high.
    peak    = !dir_q && (cnt_q >= p_act_q);
    falling = (CENTER != 0) && (dir_q || peak);
    if (falling) begin
      pwm_d = (p_act_q != '0) && (cnt_q <= duty_act_q);
    end else begin
      pwm_d = (p_act_q != '0) && (cnt_q < duty_act_q);
    end
  end

  // PWM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      duty_act_q <= '0;
      p_act_q    <= '0;
      pwm_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      duty_act_q <= duty_act_d;
      p_act_q    <= p_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_out = pwm_q & enable;

endmodule

// File: tb/tb_cascade_pi_pwm.sv
// Bench for cascade_pi_pwm: a sawtooth and a triangle instance share stimulus;
// expected duties are queued per accepted sample and compared at done.
module tb_cascade_pi_pwm;

  logic        clk = 1'b0;
  logic        rst, enable, sample_valid;
  logic [11:0] setpoint, outer_meas, inner_meas, outer_max;
  logic [15:0] kp_outer, ki_outer, kp_inner, ki_inner;
  logic [9:0]  pwm_period;
  logic        busy, done, overrun, pwm_out;
  logic [9:0]  duty_cmd;
  logic        busy_b, done_b, overrun_b, pwm_out_b;
  logic [9:0]  duty_cmd_b;

  int n_checks = 0;
  int n_fail   = 0;
  int sb_q[$];
  int done_cnt = 0;

  int hi_q_a[$], per_q_a[$], hi_q_b[$], per_q_b[$];
  int hi_run_a = 0, since_a = 0, hi_run_b = 0, since_b = 0;
  bit seen_a = 1'b0, prev_a = 1'b0, seen_b = 1'b0, prev_b = 1'b0;

  cascade_pi_pwm #(.CENTER(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .setpoint(setpoint), .outer_meas(outer_meas), .inner_meas(inner_meas),
    .kp_outer(kp_outer), .ki_outer(ki_outer), .kp_inner(kp_inner), .ki_inner(ki_inner),
    .outer_max(outer_max), .pwm_period(pwm_period), .busy(busy), .done(done),
    .overrun(overrun), .duty_cmd(duty_cmd), .pwm_out(pwm_out)
  );

  cascade_pi_pwm #(.CENTER(1)) dut_tri (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .setpoint(setpoint), .outer_meas(outer_meas), .inner_meas(inner_meas),
    .kp_outer(kp_outer), .ki_outer(ki_outer), .kp_inner(kp_inner), .ki_inner(ki_inner),
    .outer_max(outer_max), .pwm_period(pwm_period), .busy(busy_b), .done(done_b),
    .overrun(overrun_b), .duty_cmd(duty_cmd_b), .pwm_out(pwm_out_b)
  );

  always #5 clk = ~clk;

  // Pulse-width / rise-to-rise monitors and done counter, sampled on the falling edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    since_a++;
    if (pwm_out && !prev_a) begin
      if (seen_a) per_q_a.push_back(since_a);
      since_a = 0;
      seen_a  = 1'b1;
    end
    if (pwm_out) hi_run_a++;
    else if (hi_run_a != 0) begin
      hi_q_a.push_back(hi_run_a);
      hi_run_a = 0;
    end
    prev_a = pwm_out;
    since_b++;
    if (pwm_out_b && !prev_b) begin
      if (seen_b) per_q_b.push_back(since_b);
      since_b = 0;
      seen_b  = 1'b1;
    end
    if (pwm_out_b) hi_run_b++;
    else if (hi_run_b != 0) begin
      hi_q_b.push_back(hi_run_b);
      hi_run_b = 0;
    end
    prev_b = pwm_out_b;
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int sp, input int om, input int im, input int exp,
                        input bit push);
    setpoint     = 12'(sp);
    outer_meas   = 12'(om);
    inner_meas   = 12'(im);
    sample_valid = 1'b1;
    if (push) sb_q.push_back(exp);
    tick();
    sample_valid = 1'b0;
  endtask

  // n0 is the cycle offset (relative to the strobe cycle T) at which we are now.
  task automatic wait_done(input int n0);
    int n;
    int exp;
    n = n0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    if (!done) check_eq("done_timeout", 0, 1);
    else begin
      check_eq("done_latency", n, 9);
      if (sb_q.size() == 0) check_eq("sb_underflow", 0, 1);
      else begin
        exp = sb_q.pop_front();
        check_eq("duty_cmd", duty_cmd, exp);
        check_eq("duty_cmd_tri", duty_cmd_b, exp);
      end
    end
  endtask

  task automatic wait_rise_a();
    bit prev;
    bit ok;
    ok   = 1'b0;
    prev = pwm_out;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!prev && pwm_out) begin
        ok = 1'b1;
        break;
      end
      prev = pwm_out;
    end
    if (!ok) check_eq("pwm_rise_timeout", 0, 1);
  endtask

  task automatic clear_mon();
    hi_q_a.delete();
    per_q_a.delete();
    hi_q_b.delete();
    per_q_b.delete();
    seen_a = 1'b0;
    seen_b = 1'b0;
  endtask

  task automatic check_last(input string tag, input int q[$], input int exp);
    if (q.size() == 0) check_eq({tag, "_empty"}, 0, 1);
    else check_eq(tag, q[q.size()-1], exp);
  endtask

  task automatic count_high(input int n, output int ones_a, output int ones_b);
    ones_a = 0;
    ones_b = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      ones_a += int'(pwm_out);
      ones_b += int'(pwm_out_b);
    end
  endtask

  task automatic clear_integ();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  task automatic set_passthrough();
    kp_outer = 16'd256; ki_outer = 16'd0; kp_inner = 16'd256; ki_inner = 16'd0;
    outer_max = 12'd4095; pwm_period = 10'd100;
  endtask

  initial begin
    int ones_a, ones_b, d0;
    rst = 1'b1; enable = 1'b0; sample_valid = 1'b0;
    setpoint = '0; outer_meas = '0; inner_meas = '0; outer_max = '0;
    kp_outer = '0; ki_outer = '0; kp_inner = '0; ki_inner = '0; pwm_period = '0;

    // Reset values
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_duty_cmd", duty_cmd, 0);
    check_eq("rst_pwm_out", pwm_out, 0);
    check_eq("rst_done_tri", done_b, 0);
    check_eq("rst_overrun_tri", overrun_b, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    enable = 1'b1;
    set_passthrough();
    tick();

    // Proportional path: u1 = 20, duty 15
    strobe(50, 30, 5, 15, 1'b1);
    check_eq("busy_t1", busy, 1);
    check_eq("busy_t1_tri", busy_b, 1);
    wait_done(1);
    tick();
    check_eq("busy_t10", busy, 0);
    clear_mon();
    for (int i = 0; i < 350; i++) tick();
    check_last("p_hi", hi_q_a, 15);
    check_last("p_period", per_q_a, 100);

    // Anti-windup on the outer integrator
    clear_integ();
    kp_outer = 16'd0; ki_outer = 16'd256; outer_max = 12'd100;
    kp_inner = 16'd256; ki_inner = 16'd0; pwm_period = 10'd200;
    strobe(60, 0, 0, 60, 1'b1);
    wait_done(1);
    tick();
    strobe(60, 0, 0, 100, 1'b1);
    wait_done(1);
    tick();
    strobe(20, 30, 0, 50, 1'b1);
    wait_done(1);
    tick();

    // Overrun and back-to-back timing
    clear_integ();
    set_passthrough();
    d0 = done_cnt;
    strobe(80, 20, 10, 50, 1'b1);
    tick(); tick();
    check_eq("overrun_t3", overrun, 0);
    sample_valid = 1'b1;
    setpoint = 12'd10;
    tick();
    sample_valid = 1'b0;
    check_eq("overrun_t4", overrun, 1);
    tick();
    check_eq("overrun_t5", overrun, 0);
    wait_done(5);
    tick();
    check_eq("busy_t10_ovr", busy, 0);
    check_eq("single_done", done_cnt - d0, 1);
    strobe(80, 20, 10, 50, 1'b1);
    check_eq("accept_t10", busy, 1);
    wait_done(1);
    tick();

    // PWM boundaries: clamped full duty, then zero duty
    strobe(150, 0, 0, 100, 1'b1);
    wait_done(1);
    for (int i = 0; i < 120; i++) tick();
    count_high(150, ones_a, ones_b);
    check_eq("duty_full_ones", ones_a, 150);
    strobe(0, 0, 0, 0, 1'b1);
    wait_done(1);
    for (int i = 0; i < 120; i++) tick();
    count_high(150, ones_a, ones_b);
    check_eq("duty_zero_ones", ones_a, 0);

    // Duty change 40 -> 60 while the 40 pulse is high
    strobe(40, 0, 0, 40, 1'b1);
    wait_done(1);
    wait_rise_a();
    clear_mon();
    for (int i = 0; i < 4; i++) tick();
    strobe(60, 0, 0, 60, 1'b1);
    wait_done(1);
    for (int i = 0; i < 250; i++) tick();
    check_eq("mid_pulses", hi_q_a.size() >= 2, 1);
    if (hi_q_a.size() >= 2) begin
      check_eq("mid_first_hi", hi_q_a[0], 40);
      check_eq("mid_second_hi", hi_q_a[1], 60);
    end

    // Triangle vs sawtooth at duty 30
    strobe(30, 0, 0, 30, 1'b1);
    wait_done(1);
    clear_mon();
    for (int i = 0; i < 700; i++) tick();
    check_last("tri_hi", hi_q_b, 60);
    check_last("tri_period", per_q_b, 200);
    check_last("saw_hi", hi_q_a, 30);

    // Abort: enable dropped at T+5 while pwm_out is high
    wait_rise_a();
    d0 = done_cnt;
    strobe(80, 20, 10, 0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check_eq("abort_pre_pwm", pwm_out, 1);
    enable = 1'b0;
    #1;
    check_eq("abort_pwm_now", pwm_out, 0);
    check_eq("abort_pwm_now_tri", pwm_out_b, 0);
    tick();
    check_eq("abort_duty_cmd", duty_cmd, 0);
    check_eq("abort_busy", busy, 0);
    count_high(20, ones_a, ones_b);
    check_eq("abort_ones", ones_a + ones_b, 0);
    check_eq("abort_no_done", done_cnt - d0, 0);
    enable = 1'b1;
    tick();

    // Asynchronous reset mid-period and mid-computation
    strobe(50, 0, 0, 50, 1'b1);
    wait_done(1);
    wait_rise_a();
    d0 = done_cnt;
    strobe(60, 0, 0, 0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_overrun", overrun, 0);
    check_eq("arst_duty_cmd", duty_cmd, 0);
    check_eq("arst_pwm_out", pwm_out, 0);
    check_eq("arst_duty_cmd_tri", duty_cmd_b, 0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check_eq("arst_no_done", done_cnt - d0, 0);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
